// File: rtl/reduce_engine.sv
// reduce_engine: chunk-serial OR/AND/XOR/NOR reduction with lowest-set-bit search
module reduce_engine #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [WIDTH-1:0]    a_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                result_o,
    output logic                zero_o,
    output logic                found_o,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] first_one_o
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [1:0] M_AND = 2'b01;
    localparam logic [1:0] M_XOR = 2'b10;
    localparam logic [1:0] M_NOR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              found_q, found_d;
    logic [IW-1:0]     index_q, index_d;
    logic [CHUNK-1:0]  chunk;
    logic [IW-1:0]     lo;
    logic              last;

    assign last = cnt_q == CW'(NCHUNK - 1);

    // Pick the chunk being consumed this cycle and find its lowest set bit
    always_comb begin
        chunk = CHUNK'(a_q >> (cnt_q * CHUNK));
        lo = '0;
        for (int i = CHUNK - 1; i >= 0; i--) lo = chunk[i] ? IW'(i) : lo;
    end

    // Next-state: accept in IDLE/DONE, fold one chunk per RUN cycle
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        mode_d = mode_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        found_d = found_q;
        index_d = index_q;
        if (state_q == RUN) begin
            acc_d = (mode_q == M_AND) ? acc_q & (&chunk) :
                    (mode_q == M_XOR) ? acc_q ^ (^chunk) : acc_q | (|chunk);
            if (!found_q && |chunk) begin
                found_d = 1'b1;
                index_d = IW'(cnt_q * CHUNK) + lo;
            end
            cnt_d = last ? '0 : cnt_q + 1'b1;
            state_d = last ? DONE : RUN;
        end else if (start_i) begin
            a_d = a_i;
            mode_d = mode_i;
            cnt_d = '0;
            acc_d = mode_i == M_AND;
            found_d = 1'b0;
            index_d = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    // State registers; reset wins over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            mode_q <= '0;
            cnt_q <= '0;
            acc_q <= 1'b0;
            found_q <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            mode_q <= mode_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            found_q <= found_d;
            index_q <= index_d;
        end
    end

    assign busy_o = state_q == RUN;
    assign done_o = state_q == DONE;
    assign result_o = (mode_q == M_NOR) ? ~acc_q : acc_q;
    assign zero_o = ~found_q;
    assign found_o = found_q;
    assign first_one_o = index_q;
endmodule

// File: tb/tb_reduce_engine.sv
// tb_reduce_engine: directed vectors plus a per-cycle reference model for reduce_engine
module tb_reduce_engine;
    localparam int N = 4;

    logic        clk, rst, start;
    logic [1:0]  mode;
    logic [31:0] a_in;
    logic        busy, done, result, zero, found;
    logic [4:0]  first_one;

    logic        start2;
    logic [1:0]  mode2;
    logic [15:0] a2;
    logic        busy2, done2, result2, zero2, found2;
    logic [3:0]  first_one2;

    int nvec = 0;
    int nerr = 0;

    reduce_engine #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .a_i(a_in),
        .busy_o(busy), .done_o(done), .result_o(result), .zero_o(zero),
        .found_o(found), .first_one_o(first_one)
    );

    reduce_engine #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .start_i(start2), .mode_i(mode2), .a_i(a2),
        .busy_o(busy2), .done_o(done2), .result_o(result2), .zero_o(zero2),
        .found_o(found2), .first_one_o(first_one2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word reduction straight from the operand
    function automatic logic [7:0] ref_model(input logic [31:0] a, input logic [1:0] m);
        logic r;
        logic [4:0] fo;
        fo = '0;
        for (int i = 31; i >= 0; i--) if (a[i]) fo = 5'(i);
        r = (m == 2'd0) ? |a : (m == 2'd1) ? &a : (m == 2'd2) ? ^a : ~|a;
        return {r, a == 32'd0, a != 32'd0, fo};
    endfunction

    int   cyc = 0;
    int   k = 0;
    bit   run = 0;
    bit   armed = 0;
    logic e_res, e_zero, e_found;
    logic [4:0] e_first;

    // Model: an op accepted at edge k is busy through edge k+N-1 and done right after edge k+N
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            run = 0;
            armed = 1;
            {e_res, e_zero, e_found, e_first} = {1'b0, 1'b1, 1'b0, 5'd0};
        end else if (start && !(run && cyc <= k + N)) begin
            run = 1;
            k = cyc;
            {e_res, e_zero, e_found, e_first} = ref_model(a_in, mode);
        end
    end

    // Compare every cycle; data outputs only when not busy
    always @(negedge clk) begin
        if (armed) begin
            logic eb, ed;
            eb = run && (cyc < k + N);
            ed = run && (cyc == k + N);
            chk("m_busy", busy, eb);
            chk("m_done", done, ed);
            if (!eb) begin
                chk("m_result", result, e_res);
                chk("m_zero", zero, e_zero);
                chk("m_found", found, e_found);
                chk("m_first", first_one, e_first);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int e0, output int edges);
        edges = e0;
        while (!done && edges < 20) begin
            step();
            edges++;
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [1:0] m, input logic r, z, f,
                      input logic [4:0] fo, input string nm);
        int edges;
        start = 1'b1;
        a_in = a;
        mode = m;
        step();
        start = 1'b0;
        a_in = $urandom;
        mode = 2'($urandom);
        wait_done(1, edges);
        chk({nm, "_latency"}, edges, 5);
        chk({nm, "_result"}, result, r);
        chk({nm, "_zero"}, zero, z);
        chk({nm, "_found"}, found, f);
        chk({nm, "_first"}, first_one, fo);
    endtask

    initial begin
        int edges;
        rst = 1'b1;
        start = 1'b0;
        mode = 2'd0;
        a_in = '0;
        start2 = 1'b0;
        mode2 = 2'd0;
        a2 = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_found", found, 0);
        chk("rst_first", first_one, 0);

        op(32'h0000_0000, 2'd0, 0, 1, 0, 5'd0, "or_zero");
        step();
        op(32'h0001_0000, 2'd0, 1, 0, 1, 5'd16, "or_bit16");
        repeat (3) step();
        chk("hold_first", first_one, 16);
        op(32'hFFFF_FFFF, 2'd1, 1, 0, 1, 5'd0, "and_ones");
        op(32'hFFFF_FFFE, 2'd1, 0, 0, 1, 5'd1, "and_b2b");
        step();
        op(32'h8000_0007, 2'd2, 0, 0, 1, 5'd0, "xor_four");
        op(32'h0000_0000, 2'd3, 1, 1, 0, 5'd0, "nor_zero");
        op(32'hF0F0_F0F0, 2'd3, 0, 0, 1, 5'd4, "nor_set");
        op(32'h0000_0300, 2'd2, 0, 0, 1, 5'd8, "xor_pair");
        op(32'h0100_0000, 2'd2, 1, 0, 1, 5'd24, "xor_single");
        op(32'h7FFF_FFFF, 2'd1, 0, 0, 1, 5'd0, "and_msb0");
        step();

        // start during RUN is ignored
        start = 1'b1;
        a_in = 32'h0000_0001;
        mode = 2'd0;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        a_in = 32'h8000_0000;
        step();
        start = 1'b0;
        wait_done(3, edges);
        chk("ign_latency", edges, 5);
        chk("ign_result", result, 1);
        chk("ign_found", found, 1);
        chk("ign_first", first_one, 0);
        step();

        // reset in the third RUN cycle aborts the op
        start = 1'b1;
        a_in = 32'h0000_FF00;
        mode = 2'd3;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 1);
        chk("abort_found", found, 0);
        chk("abort_first", first_one, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_done", done, 0);
        end

        // reset beats start
        start = 1'b1;
        rst = 1'b1;
        a_in = 32'h0000_0010;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("prio_busy", busy, 0);
        step();
        chk("prio_idle", busy, 0);

        // single-chunk instance
        start2 = 1'b1;
        a2 = 16'h0100;
        mode2 = 2'd0;
        step();
        start2 = 1'b0;
        a2 = 16'hFFFF;
        chk("w16_busy", busy2, 1);
        edges = 1;
        while (!done2 && edges < 20) begin
            step();
            edges++;
        end
        chk("w16_latency", edges, 2);
        chk("w16_result", result2, 1);
        chk("w16_zero", zero2, 0);
        chk("w16_found", found2, 1);
        chk("w16_first", first_one2, 8);
        step();
        chk("w16_idle", done2, 0);
        chk("w16_hold", first_one2, 8);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
